garbage_sender: RTL and testbench
=================================

GARBAGE_SENDER -- requirements
Module: garbage_sender

Interface
REQ-001 SHALL expose: clk  input  1  rising-edge clock.
REQ-002 SHALL expose: reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL expose: rng  input  32  free-running random word; only rng[3:0] used.
REQ-004 SHALL expose: clear_valid  input  1  one-cycle pulse; local game finished a piece's line-clear evaluation.
REQ-005 SHALL expose: clear_lines  input  3  lines cleared by that piece, 0..4; sampled only when clear_valid=1.
REQ-006 SHALL expose: target_state  input  state_type  current state of the opponent tetris engine.
REQ-007 SHALL expose: bar_valid  output  1  one-cycle request; integration mux drives BAR onto the opponent's ctrl this cycle, overriding user input.
REQ-008 SHALL expose: bar_mask  output  10  one-hot hole column of the row being sent; bit i = column i; held stable from bar_valid until the next issue.
REQ-009 SHALL expose: pending  output  5  garbage rows queued, 0..20.
REQ-010 SHALL expose: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL map clear_lines to attack rows: 0->0, 1->0, 2->1, 3->2, 4->4; values 5..7 -> 0.
REQ-012 SHALL update pending each cycle as min(20, pending + attack - issued), where issued=1 in the cycle bar_valid=1; arithmetic in 6 bits before saturation.
REQ-013 SHALL treat a clear_valid coinciding with an issue as both applied in the same cycle, e.g. pending 3, attack 2, issue -> 4.
REQ-014 SHALL implement FSM states IDLE, ISSUE, ACK, SETTLE.
REQ-015 IDLE -> ISSUE when pending != 0 and target_state == WAIT; otherwise stay.
REQ-016 ISSUE SHALL last exactly one cycle with bar_valid=1 and bar_mask loaded, then go to ACK.
REQ-017 ACK -> SETTLE when target_state == BAR; if target_state is still WAIT 4 cycles after ISSUE, return to IDLE and re-increment pending by 1 (lost request, saturating).
REQ-018 SETTLE -> IDLE when target_state == WAIT; no new issue before the opponent returns to WAIT.
REQ-019 Hole column h = rng[3:0] if < 10, else rng[3:0] - 10; bar_mask = 1 << h, sampled in the ISSUE cycle; bar_mask SHALL never be zero after the first issue.
REQ-020 When target_state is END or INIT in any cycle, pending SHALL clear to 0, the FSM SHALL go to IDLE, and any clear_valid in that same cycle SHALL be discarded.
REQ-021 bar_valid SHALL be low in every state except ISSUE; at most one row per ISSUE.
REQ-022 Latency: with pending > 0 and target in WAIT, bar_valid SHALL assert the cycle after entry to IDLE; from clear_valid in IDLE with the target in WAIT, bar_valid SHALL assert 2 cycles later (pending registered, then ISSUE).
REQ-023 busy SHALL equal (FSM != IDLE), registered with the state.

Reset
REQ-024 While reset_n=0, the block SHALL be in IDLE with pending=0, bar_valid=0, bar_mask=0, busy=0, asynchronously and independent of clk.
REQ-025 Reset asserted in ISSUE SHALL force bar_valid low immediately; the row is dropped, not retried.
REQ-026 After reset deassertion, the first clock edge SHALL evaluate REQ-015 normally.

Verification
REQ-027 Tetris: target held at WAIT, clear_valid with clear_lines=4 -> pending 4; four bar_valid pulses, each after the target responds BAR->WAIT; pending ends at 0.
REQ-028 Saturation: pending=19, clear_lines=3 -> pending 20; a further clear_lines=4 -> pending stays 20.
REQ-029 Hole mapping: rng[3:0]=13 at ISSUE -> bar_mask=10'b0000001000; rng[3:0]=9 -> 10'b1000000000.
REQ-030 Lost request: target stays WAIT after bar_valid -> after 4 cycles FSM returns to IDLE, pending restored (e.g. 2 stays 2), reissue follows.
REQ-031 Flush: pending=7, target_state goes to END with a simultaneous clear_valid (clear_lines=2) -> pending=0, FSM IDLE, no bar_valid.
REQ-032 Async reset: reset_n pulled low mid-cycle during ISSUE -> bar_valid, pending, busy drop to 0 before the next clk edge.

Source files
------------

// File: rtl/garbage_pkg.sv
// garbage_pkg: shared types for the versus-mode tetris blocks.
// state_type is the engine state seen by the garbage sender.
package garbage_pkg;

  typedef enum logic [2:0] {
    INIT,
    WAIT,
    SPAWN,
    FALL,
    LOCK,
    CLEAR,
    BAR,
    END
  } state_type;

endpackage

// File: rtl/garbage_sender.sv
// garbage_sender: turns local line clears into garbage rows
// and pushes them one at a time into the opponent engine.
module garbage_sender
  import garbage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rng,
  input  logic        clear_valid,
  input  logic [2:0]  clear_lines,
  input  state_type   target_state,
  output logic        bar_valid,
  output logic [9:0]  bar_mask,
  output logic [4:0]  pending,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACK,
    SETTLE
  } fsm_t;

  fsm_t       state;
  logic [1:0] ack_cnt;
  logic [2:0] attack;
  logic [3:0] hole;
  logic [5:0] sum;
  logic       flush;
  logic       lost;
  logic       unused_rng;

  assign unused_rng = ^rng[31:4];

  assign flush = (target_state == END) ||
                 (target_state == INIT);

  assign lost = (state == ACK) &&
                (ack_cnt == 2'd3) &&
                (target_state == WAIT);

  assign hole = (rng[3:0] >= 4'd10) ?
                rng[3:0] - 4'd10 : rng[3:0];

  assign sum = {1'b0, pending}
             + {3'b0, attack}
             + {5'b0, lost}
             - {5'b0, bar_valid};

  // lines cleared -> garbage rows sent
  always_comb begin
    attack = 3'd0;
    if (clear_valid) begin
      case (clear_lines)
        3'd2:    attack = 3'd1;
        3'd3:    attack = 3'd2;
        3'd4:    attack = 3'd4;
        default: attack = 3'd0;
      endcase
    end
  end

  // queued rows; a lost request puts its row back
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else if (sum > 6'd20) begin
      pending <= 5'd20;
    end else begin
      pending <= sum[4:0];
    end
  end

  // one row per handshake with the opponent engine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bar_valid <= 1'b0;
      bar_mask  <= '0;
      busy      <= 1'b0;
      ack_cnt   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      bar_valid <= 1'b0;
      busy      <= 1'b0;
      ack_cnt   <= '0;
    end else begin
      bar_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pending != 5'd0 &&
              target_state == WAIT) begin
            state     <= ISSUE;
            bar_valid <= 1'b1;
            bar_mask  <= 10'd1 << hole;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          state   <= ACK;
          ack_cnt <= '0;
        end
        ACK: begin
          if (target_state == BAR) begin
            state <= SETTLE;
          end else if (ack_cnt == 2'd3) begin
            if (target_state == WAIT) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            ack_cnt <= ack_cnt + 2'd1;
          end
        end
        SETTLE: begin
          if (target_state == WAIT) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_garbage_sender.sv
// tb_garbage_sender: scoreboard bench for garbage_sender
// with a transaction-level model of the garbage protocol.
module tb_garbage_sender;
  import garbage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rng = '0;
  logic        clear_valid = 1'b0;
  logic [2:0]  clear_lines = '0;
  state_type   target_state = WAIT;
  logic        bar_valid;
  logic [9:0]  bar_mask;
  logic [4:0]  pending;
  logic        busy;

  garbage_sender dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rng          (rng),
    .clear_valid  (clear_valid),
    .clear_lines  (clear_lines),
    .target_state (target_state),
    .bar_valid    (bar_valid),
    .bar_mask     (bar_mask),
    .pending      (pending),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       bv;
    bit [9:0] mask;
    int       pend;
    bit       busy;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   bv_cnt = 0;

  // model: queue depth plus one outstanding row
  int       m_pend = 0;
  int       m_age = 0;
  bit       m_valid = 1'b0;
  bit       m_out = 1'b0;
  bit       m_seen = 1'b0;
  bit [9:0] m_mask = '0;
  int       atk;
  int       h;
  bit       lost;
  bit       nv;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int atk_of(input int cl);
    int tbl [8] = '{0, 0, 1, 2, 4, 0, 0, 0};
    return tbl[cl];
  endfunction

  // reference model: predicts outputs after each edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend  = 0;
      m_age   = 0;
      m_valid = 1'b0;
      m_out   = 1'b0;
      m_seen  = 1'b0;
      m_mask  = '0;
      sbq.delete();
    end else begin
      if (target_state == END ||
          target_state == INIT) begin
        m_pend  = 0;
        m_valid = 1'b0;
        m_out   = 1'b0;
        m_seen  = 1'b0;
        m_age   = 0;
      end else begin
        atk  = clear_valid ? atk_of(int'(clear_lines)) : 0;
        lost = 1'b0;
        nv   = 1'b0;
        if (m_valid) begin
          m_out  = 1'b1;
          m_seen = 1'b0;
          m_age  = 1;
        end else if (m_out) begin
          if (!m_seen) begin
            if (target_state == BAR) begin
              m_seen = 1'b1;
            end else if (m_age >= 4 &&
                         target_state == WAIT) begin
              lost  = 1'b1;
              m_out = 1'b0;
            end else begin
              m_age++;
            end
          end else if (target_state == WAIT) begin
            m_out = 1'b0;
          end
        end else if (m_pend != 0 &&
                     target_state == WAIT) begin
          nv     = 1'b1;
          h      = int'(rng[3:0]) % 10;
          m_mask = '0;
          m_mask[h] = 1'b1;
        end
        m_pend = m_pend + atk
               - (m_valid ? 1 : 0)
               + (lost ? 1 : 0);
        if (m_pend > 20) m_pend = 20;
        m_valid = nv;
      end
      sbq.push_back('{m_valid, m_mask, m_pend,
                      m_out || m_valid});
    end
  end

  // monitor: pops one expectation per cycle
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n || sbq.size() == 0)
      e = '{1'b0, 10'd0, 0, 1'b0};
    else
      e = sbq.pop_front();
    chk("bar_valid", int'(bar_valid), int'(e.bv));
    chk("bar_mask", int'(bar_mask), int'(e.mask));
    chk("pending", int'(pending), e.pend);
    chk("busy", int'(busy), int'(e.busy));
    if (bar_valid) bv_cnt++;
  end

  task automatic drive(input bit cv,
                       input logic [2:0] cl,
                       input state_type ts);
    @(posedge clk);
    #1;
    clear_valid  = cv;
    clear_lines  = cl;
    target_state = ts;
    rng          = $urandom;
  endtask

  task automatic wait_issue(input logic [31:0] r,
                            output int n);
    n   = 0;
    rng = r;
    while (n < 20) begin
      @(posedge clk);
      #1;
      if (bar_valid) break;
      clear_valid  = 1'b0;
      target_state = WAIT;
      rng          = r;
      n++;
    end
    chk("issue_seen", int'(bar_valid), 1);
  endtask

  // opponent: answers a row with BAR unless it drops it
  task automatic play(input int n, input bit wild);
    int ow;
    int ob;
    ow = 0;
    ob = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bar_valid &&
          (!wild || $urandom_range(0, 3) != 0)) begin
        ow = wild ? $urandom_range(1, 5) : 1;
        ob = wild ? $urandom_range(1, 3) : 2;
      end
      if (ow > 0) begin
        ow--;
        target_state = WAIT;
      end else if (ob > 0) begin
        ob--;
        target_state = BAR;
      end else if (wild && $urandom_range(0, 9) == 0) begin
        target_state = SPAWN;
      end else begin
        target_state = WAIT;
      end
      if (wild && $urandom_range(0, 79) == 0)
        target_state = $urandom_range(0, 1) ? END : INIT;
      clear_valid = wild && ($urandom_range(0, 5) == 0);
      clear_lines = 3'($urandom_range(0, 7));
      rng         = $urandom;
    end
  endtask

  initial begin
    int n;
    logic [9:0] want;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    drive(0, 0, WAIT);

    bv_cnt = 0;
    drive(1, 3'd4, WAIT);
    play(40, 1'b0);
    chk("tetris_rows", bv_cnt, 4);
    chk("tetris_pending", int'(pending), 0);

    repeat (4) drive(1, 3'd4, SPAWN);
    drive(1, 3'd3, SPAWN);
    drive(1, 3'd2, SPAWN);
    drive(1, 3'd3, SPAWN);
    chk("sat_19", int'(pending), 19);
    drive(1, 3'd4, SPAWN);
    chk("sat_20", int'(pending), 20);
    drive(0, 3'd0, SPAWN);
    chk("sat_hold", int'(pending), 20);

    drive(0, 3'd0, INIT);
    drive(1, 3'd4, SPAWN);
    drive(1, 3'd3, SPAWN);
    drive(1, 3'd2, SPAWN);
    drive(0, 3'd0, SPAWN);
    chk("flush_pre", int'(pending), 7);
    drive(1, 3'd2, END);
    drive(0, 3'd0, WAIT);
    chk("flush_pending", int'(pending), 0);
    chk("flush_busy", int'(busy), 0);
    drive(0, 3'd0, WAIT);
    chk("flush_no_bar", int'(bar_valid), 0);

    drive(1, 3'd3, SPAWN);
    drive(0, 3'd0, SPAWN);
    chk("hole_pre", int'(pending), 2);
    wait_issue(32'd13, n);
    want = 10'b0000001000;
    chk("hole13_mask", int'(bar_mask), int'(want));
    wait_issue(32'd9, n);
    chk("lost_gap", n, 5);
    chk("lost_pending", int'(pending), 2);
    want = 10'b1000000000;
    chk("hole9_mask", int'(bar_mask), int'(want));
    play(30, 1'b0);
    chk("drain_pending", int'(pending), 0);

    drive(1, 3'd2, WAIT);
    wait_issue(32'd0, n);
    chk("pre_rst_busy", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_bar_valid", int'(bar_valid), 0);
    chk("arst_pending", int'(pending), 0);
    chk("arst_busy", int'(busy), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    play(1500, 1'b1);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
